if_fetch_queue: RTL

- Parametrised instruction-fetch stage; successor to the single-register PC/IF pipe stage.
- Decouples the PC generator from decode with a DEPTH-entry {pc, instr} queue.
- Supports multiple outstanding imem requests (req/gnt, in-order rvalid), valid/ready back-pressure from decode, and a redirect (jump/branch) that flushes queued and in-flight fetches.
- Sits between imem and the ID stage.

---
 rtl/if_fetch_queue.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/if_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_queue
// Description : Instruction-fetch stage with a DEPTH-entry {pc, instr} queue
//               between the imem request/response port and decode. Supports
//               up to MAX_OUTST in-order outstanding imem requests, valid/ready
//               back-pressure towards decode, and a redirect that flushes both
//               queued and in-flight fetches.
//               Build option IF_NOP_FILL_EN: when defined, out_instr shows
//               addi x0,x0,0 (32'h00000013) while out_valid is low; otherwise
//               it shows 32'h00000000.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_queue #(
    parameter int              XLEN      = 32,
    parameter int              DEPTH     = 4,
    parameter int              MAX_OUTST = 2,
    parameter logic [XLEN-1:0] RESET_PC  = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pc4,
    output logic [31:0]     out_instr
);

    // Widths of the queue pointers, the occupancy counter, the outstanding
    // counter and of the credit sum (occupancy + outstanding).
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int SW = $clog2(DEPTH + MAX_OUTST + 1);

    localparam logic [XLEN-1:0] c_pc_step = XLEN'(4);

`ifdef IF_NOP_FILL_EN
    localparam logic [31:0] c_fill_instr = 32'h0000_0013;
`else
    localparam logic [31:0] c_fill_instr = 32'h0000_0000;
`endif

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [XLEN-1:0] r_fetch_pc;
    logic [XLEN-1:0] r_resp_pc;
    logic [OW-1:0]   r_outst;
    logic [OW-1:0]   r_drop_cnt;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;
    logic [XLEN-1:0] r_pc_mem    [DEPTH];
    logic [31:0]     r_instr_mem [DEPTH];

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic w_credit_ok;
    logic w_fire;
    logic w_rsp;
    logic w_drop;
    logic w_push;
    logic w_pop;

    // A new request is allowed only when every in-flight response (dropped
    // ones included) is guaranteed a queue slot, so the queue cannot overflow.
    always_comb begin
        w_credit_ok = ((SW'(r_count) + SW'(r_outst)) < SW'(DEPTH)) &&
                      (r_outst < OW'(MAX_OUTST));
        imem_req    = !reset && !redirect_valid && w_credit_ok;
        imem_addr   = r_fetch_pc;
        w_fire      = imem_req && imem_gnt;
        // A response with nothing outstanding (e.g. a stray one after reset)
        // is not a response at all.
        w_rsp       = imem_rvalid && (r_outst != '0);
        w_drop      = w_rsp && (r_drop_cnt != '0);
        w_push      = w_rsp && (r_drop_cnt == '0) && !redirect_valid;
        out_valid   = (r_count != '0) && !redirect_valid;
        w_pop       = out_valid && out_ready;
    end

    // Head of the queue is read straight from storage; the fill word is shown
    // whenever the head is not being presented.
    always_comb begin
        out_pc    = r_pc_mem[r_rd_ptr];
        out_pc4   = r_pc_mem[r_rd_ptr] + c_pc_step;
        out_instr = out_valid ? r_instr_mem[r_rd_ptr] : c_fill_instr;
    end

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------

    // Next fetch address: redirect target, or step past each granted request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_fetch_pc <= redirect_pc;
        end else if (w_fire) begin
            r_fetch_pc <= r_fetch_pc + c_pc_step;
        end
    end

    // Outstanding request count and the number of responses still to discard.
    // On redirect every request still in flight after this cycle is stale.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_outst    <= '0;
            r_drop_cnt <= '0;
        end else if (redirect_valid) begin
            r_outst    <= r_outst - OW'(w_rsp);
            r_drop_cnt <= r_outst - OW'(w_rsp);
        end else begin
            r_outst <= r_outst + OW'(w_fire) - OW'(w_rsp);
            if (w_drop) begin
                r_drop_cnt <= r_drop_cnt - OW'(1);
            end
        end
    end

    // PC tagged onto the next kept response; responses return in order, so
    // it simply advances by one instruction per pushed entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_resp_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_resp_pc <= redirect_pc;
        end else if (w_push) begin
            r_resp_pc <= r_resp_pc + c_pc_step;
        end
    end

    // Queue pointers and occupancy; redirect empties the queue outright.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (redirect_valid) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Queue storage: cleared on reset so the idle head reads as pc 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pc_mem[i]    <= '0;
                r_instr_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_pc_mem[r_wr_ptr]    <= r_resp_pc;
            r_instr_mem[r_wr_ptr] <= imem_rdata;
        end
    end

endmodule
`default_nettype wire
